rtc_read_sequencer: RTL and testbench
=====================================

Name: rtc_read_sequencer

Overview:
- Controller that sequences the 2-bit register selector (selec -> registered 7-bit direc) through all four entries and issues one bus read per entry.
- Each read goes through a req/done handshake to the RTC bus-timing block; the returned byte is captured into a per-entry output register.
- Sits between the refresh timebase and the VGA text/digit renderer, which consumes the four captured bytes.

Parameters:
- N_SEL, 4, number of selector entries swept per frame (fixed 4; the selector is 2 bits).
- DATA_W, 8, width of bus read data.
- ADDR_W, 7, width of direc and bus_addr.
- TIMEOUT, 255, max cycles to wait for bus_done per read (8-bit counter).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, single-cycle pulse that requests one full sweep.
- selec, out, 2, index driven to the selector.
- direc, in, 7, address returned by the selector (valid 1 cycle after selec changes).
- bus_req, out, 1, read request to the bus-timing block.
- bus_addr, out, 7, address for the current request.
- bus_done, in, 1, single-cycle pulse: read complete, bus_rdata valid.
- bus_rdata, in, 8, read data.
- dato0..dato3, out, 8 each, captured bytes for entries 0..3.
- busy, out, 1, high from accepted start until the sweep ends.
- sweep_done, out, 1, single-cycle pulse at end of sweep.
- timeout_err, out, 1, sticky: some read in the last sweep timed out; cleared on next accepted start.

Behaviour:
- Reset values: selec=0, bus_req=0, bus_addr=0, dato0..3=0x00, busy=0, sweep_done=0, timeout_err=0, state IDLE, idx=0, timeout counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: on start -> SEL; idx=0, selec=0, busy=1, timeout_err=0.
  - SEL: wait 1 cycle for the selector register -> SETTLE.
  - SETTLE: latch bus_addr=direc, bus_req=1, clear timeout counter -> WAIT.
  - WAIT: bus_req held high.
    - bus_done=1: capture bus_rdata into dato[idx], bus_req=0 -> NEXT.
    - Counter reaches TIMEOUT: bus_req=0, dato[idx] unchanged, timeout_err=1 -> NEXT.
    - bus_done and timeout in the same cycle: bus_done wins (data captured, no error).
  - NEXT:
    - idx<3: idx+1, selec=idx+1 -> SEL.
    - idx==3: busy=0, sweep_done=1, selec=0 -> IDLE.
- Timing per read with zero-wait bus_done (done in the first WAIT cycle): SEL 1 + SETTLE 1 + WAIT 1 + NEXT 1 = 4 cycles.
- Sweep latency: start to sweep_done is 4 x 4 = 16 cycles minimum. sweep_done is asserted in the cycle after the final NEXT.
- start while busy: ignored, not queued.
- bus_done outside WAIT: ignored.
- bus_req drops in the cycle after bus_done is sampled; the bus block must not issue a second done.
- idx is 2 bits and never wraps mid-sweep; the sweep ends at idx==3.
- reset mid-sweep: immediate return to IDLE.
  - bus_req drops on the next edge.
  - dato registers return to 0x00.
  - A pending bus_done after reset is ignored.
- direc=0x00 (entry 0) is a valid address; no special casing.

Decomposition:
- Shared package: state encoding (IDLE, SEL, SETTLE, WAIT, NEXT), N_SEL, TIMEOUT default, and selector address constants (0x00, 0x45, 0x41, 0x4A) for bench use.
- One natural sub-module: rtc_timeout_counter (clear/enable/expired), instantiated once.
- Top-level integration instantiates the existing selector alongside this block.

Test Plan:
- Basic sweep:
  - Stimulus: reset, then start pulse; bus model returns done 1 cycle after req with rdata 0x11, 0x22, 0x33, 0x44.
  - Response: bus_addr sequence 0x00, 0x45, 0x41, 0x4A; dato0..3=0x11/0x22/0x33/0x44; sweep_done exactly 16 cycles after start; busy low afterwards.
- Slow bus:
  - Stimulus: done arrives 10 cycles after each req.
  - Response: bus_req held high for the full wait; correct captures; timeout_err=0.
- Timeout:
  - Stimulus: no done for entry 2.
  - Response: bus_req drops after 255 WAIT cycles; dato2 keeps its prior value; timeout_err=1 after the sweep; entry 3 still read.
- start while busy:
  - Stimulus: second start 5 cycles into a sweep.
  - Response: ignored; exactly one sweep_done.
- Reset mid-op:
  - Stimulus: reset asserted while in WAIT for entry 1.
  - Response: next cycle bus_req=0, busy=0, dato0..3=0x00, selec=0; a late bus_done causes no capture.
- Simultaneous done and timeout:
  - Stimulus: done asserted in the cycle the counter expires.
  - Response: data captured; timeout_err stays 0.

Source files
------------

// File: rtl/rtc_read_sequencer_pkg.sv
// Shared definitions for the RTC read sequencer: FSM state encoding,
// sizing constants and the selector address table. The address table
// mirrors the contents of the external selector register so that
// benches can predict bus_addr for each selector index.
package rtc_read_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETTLE,
        ST_WAIT,
        ST_NEXT
    } state_t;

    localparam int unsigned N_SEL           = 4;
    localparam int unsigned DATA_W_DEFAULT  = 8;
    localparam int unsigned ADDR_W_DEFAULT  = 7;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [6:0] SEL_ADDR0 = 7'h00;
    localparam logic [6:0] SEL_ADDR1 = 7'h45;
    localparam logic [6:0] SEL_ADDR2 = 7'h41;
    localparam logic [6:0] SEL_ADDR3 = 7'h4A;

    function automatic logic [6:0] sel_addr(input logic [1:0] s);
        logic [6:0] a;
        case (s)
            2'd0:    a = SEL_ADDR0;
            2'd1:    a = SEL_ADDR1;
            2'd2:    a = SEL_ADDR2;
            default: a = SEL_ADDR3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/rtc_read_sequencer_timeout_counter.sv
// rtc_timeout_counter: counts cycles spent waiting for a bus read.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : zero the count (start of a new read)
//   enable     : count this cycle (waiting for bus_done)
//   expired    : high during the LIMIT-th enabled cycle since clear
module rtc_timeout_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] cnt;

    // The count equals the number of enabled cycles already elapsed, so
    // matching LIMIT-1 flags the final allowed cycle itself.
    assign expired = enable && (cnt == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: sweeps the 2-bit RTC register selector through all
// four entries, issuing one req/done bus read per entry and capturing
// each returned byte.
//   clk, reset      : system clock, synchronous active-high reset
//   start           : pulse requesting one sweep (ignored while busy)
//   selec / direc   : selector index out, registered address back
//   bus_req/addr    : read request and address to the bus-timing block
//   bus_done/rdata  : read-complete pulse and data
//   dato0..dato3    : captured bytes for entries 0..3
//   busy            : sweep in progress
//   sweep_done      : one-cycle pulse at end of sweep
//   timeout_err     : sticky, a read in the last sweep timed out
module rtc_read_sequencer
    import rtc_read_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [1:0]        selec,
    input  logic [ADDR_W-1:0] direc,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_done,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [DATA_W-1:0] dato0,
    output logic [DATA_W-1:0] dato1,
    output logic [DATA_W-1:0] dato2,
    output logic [DATA_W-1:0] dato3,
    output logic              busy,
    output logic              sweep_done,
    output logic              timeout_err
);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        selec_d;
    logic              bus_req_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [DATA_W-1:0] dato_q [N_SEL];
    logic [DATA_W-1:0] dato_d [N_SEL];
    logic              busy_d;
    logic              sweep_done_d;
    logic              err_d;
    logic              cnt_clear;
    logic              cnt_en;
    logic              expired;

    rtc_timeout_counter #(
        .WIDTH (8),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        selec_d      = selec;
        bus_req_d    = bus_req;
        bus_addr_d   = bus_addr;
        dato_d       = dato_q;
        busy_d       = busy;
        sweep_done_d = 1'b0;
        err_d        = timeout_err;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEL;
                    idx_d   = '0;
                    selec_d = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_SEL: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                bus_addr_d = direc;
                bus_req_d  = 1'b1;
                cnt_clear  = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // done takes priority over a simultaneous expiry
                if (bus_done) begin
                    dato_d[idx_q] = bus_rdata;
                    bus_req_d     = 1'b0;
                    state_d       = ST_NEXT;
                end else if (expired) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q != 2'(N_SEL - 1)) begin
                    idx_d   = idx_q + 2'd1;
                    selec_d = idx_q + 2'd1;
                    state_d = ST_SEL;
                end else begin
                    busy_d       = 1'b0;
                    sweep_done_d = 1'b1;
                    selec_d      = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            selec       <= '0;
            bus_req     <= 1'b0;
            bus_addr    <= '0;
            dato_q      <= '{default: '0};
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            selec       <= selec_d;
            bus_req     <= bus_req_d;
            bus_addr    <= bus_addr_d;
            dato_q      <= dato_d;
            busy        <= busy_d;
            sweep_done  <= sweep_done_d;
            timeout_err <= err_d;
        end
    end

    assign dato0 = dato_q[0];
    assign dato1 = dato_q[1];
    assign dato2 = dato_q[2];
    assign dato3 = dato_q[3];

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: models the external selector and a
// configurable-latency bus block, predicts each sweep from per-entry
// delays, and checks results through a scoreboard monitor.
module tb_rtc_read_sequencer;
    import rtc_read_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] selec;
    logic [6:0] direc;
    logic       bus_req;
    logic [6:0] bus_addr;
    logic       bus_done = 1'b0;
    logic [7:0] bus_rdata = 8'h00;
    logic [7:0] dato0, dato1, dato2, dato3;
    logic       busy, sweep_done, timeout_err;

    rtc_read_sequencer #(
        .DATA_W  (8),
        .ADDR_W  (7),
        .TIMEOUT (255)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .selec       (selec),
        .direc       (direc),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_done    (bus_done),
        .bus_rdata   (bus_rdata),
        .dato0       (dato0),
        .dato1       (dato1),
        .dato2       (dato2),
        .dato3       (dato3),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // external selector: registered address lookup
    always @(posedge clk) direc <= sel_addr(selec);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus block model ----------------
    // cfg_delay[i] = WAIT cycles before done for entry i (255 = never)
    int         cfg_delay [4];
    logic [7:0] cfg_rdata [4];
    int sweep_id = 0, seen_id = 0, ent = 0, wcnt = 0;
    int inject_req = 0, inject_seen = 0;
    bit responded = 1'b0, was_req = 1'b0;

    always @(negedge clk) begin
        bus_done = 1'b0;
        if (seen_id != sweep_id) begin
            seen_id = sweep_id;
            ent = 0;
        end
        if (reset) begin
            responded = 1'b0;
            wcnt = 0;
            was_req = 1'b0;
        end else begin
            if (bus_req && !responded) begin
                if (wcnt == cfg_delay[ent]) begin
                    bus_done  = 1'b1;
                    bus_rdata = cfg_rdata[ent];
                    responded = 1'b1;
                end
                wcnt++;
            end
            if (!bus_req && was_req) begin
                ent = (ent + 1) % 4;
                responded = 1'b0;
                wcnt = 0;
            end
            was_req = bus_req;
        end
        if (inject_seen != inject_req) begin
            inject_seen = inject_req;
            bus_done  = 1'b1;
            bus_rdata = 8'hEE;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [3:0][7:0] d;
        logic            err;
        int              lat;
        int              start_cyc;
    } sweep_exp_t;

    typedef struct packed {
        logic [6:0] addr;
        int         width;
    } req_exp_t;

    sweep_exp_t      sweep_q [$];
    req_exp_t        req_q [$];
    logic [3:0][7:0] model_dato = '0;

    task automatic issue_sweep();
        sweep_exp_t e;
        req_exp_t   r;
        int         w;
        int         lat;
        bit         any_to;
        lat = 0;
        any_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cfg_delay[i] < 255) begin
                w = cfg_delay[i] + 1;
                model_dato[i] = cfg_rdata[i];
            end else begin
                w = 255;
                any_to = 1'b1;
            end
            r.addr  = sel_addr(2'(i));
            r.width = w;
            req_q.push_back(r);
            lat += 3 + w;
        end
        e.d   = model_dato;
        e.err = any_to;
        e.lat = lat;
        @(negedge clk);
        sweep_id++;
        start = 1'b1;
        e.start_cyc = cyc + 1;
        sweep_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", timeout_err, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sweep_ends_in_budget", busy, 0);
        repeat (2) @(negedge clk);
        check("sweep_done_seen", sweep_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    bit         in_req = 1'b0;
    int         hi_cnt = 0;
    int         ndone = 0;
    req_exp_t   cur_req;
    sweep_exp_t cur_sw;

    always @(negedge clk) begin
        if (reset) begin
            in_req = 1'b0;
            hi_cnt = 0;
        end else begin
            if (bus_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    hi_cnt = 0;
                    if (req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: bus_addr=%0h with no request expected", bus_addr);
                        cur_req.width = 0;
                    end else begin
                        cur_req = req_q.pop_front();
                        check("bus_addr", bus_addr, cur_req.addr);
                    end
                end
                hi_cnt++;
            end else if (in_req) begin
                in_req = 1'b0;
                check("bus_req_width", hi_cnt, cur_req.width);
            end
            if (sweep_done) begin
                ndone++;
                if (sweep_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sweep_done: at cycle %0d, none expected", cyc);
                end else begin
                    cur_sw = sweep_q.pop_front();
                    check("dato0", dato0, cur_sw.d[0]);
                    check("dato1", dato1, cur_sw.d[1]);
                    check("dato2", dato2, cur_sw.d[2]);
                    check("dato3", dato3, cur_sw.d[3]);
                    check("timeout_err", timeout_err, cur_sw.err);
                    check("busy_at_done", busy, 0);
                    check("selec_at_done", selec, 0);
                    check("sweep_latency", cyc - cur_sw.start_cyc, cur_sw.lat);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int nd0;
        reset = 1'b1;
        start = 1'b0;
        cfg_delay = '{0, 0, 0, 0};
        cfg_rdata = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        check("rst_selec", selec, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_dato0", dato0, 0);
        check("rst_dato1", dato1, 0);
        check("rst_dato2", dato2, 0);
        check("rst_dato3", dato3, 0);
        check("rst_busy", busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic zero-wait sweep: 16 cycles start to sweep_done
        cfg_delay = '{0, 0, 0, 0};
        cfg_rdata = '{8'h11, 8'h22, 8'h33, 8'h44};
        issue_sweep();
        wait_idle(100);

        // slow bus
        cfg_delay = '{10, 10, 10, 10};
        for (int i = 0; i < 4; i++) cfg_rdata[i] = 8'($urandom);
        issue_sweep();
        wait_idle(200);

        // entry 2 never answers
        cfg_delay = '{2, 3, 255, 1};
        for (int i = 0; i < 4; i++) cfg_rdata[i] = 8'($urandom);
        issue_sweep();
        wait_idle(1200);

        // second start 5 cycles in must be ignored
        cfg_delay = '{1, 0, 2, 0};
        for (int i = 0; i < 4; i++) cfg_rdata[i] = 8'($urandom);
        nd0 = ndone;
        issue_sweep();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);
        repeat (30) @(negedge clk);
        check("single_sweep_done", ndone - nd0, 1);
        check("idle_after_ignored_start", busy, 0);

        // done in the same cycle the counter expires
        cfg_delay = '{0, 254, 0, 0};
        for (int i = 0; i < 4; i++) cfg_rdata[i] = 8'($urandom);
        issue_sweep();
        wait_idle(1200);

        // randomized sweeps
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 4; i++) begin
                cfg_delay[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 15));
                cfg_rdata[i] = 8'($urandom);
            end
            issue_sweep();
            wait_idle(1200);
        end

        // reset while waiting on entry 1
        cfg_delay = '{0, 100, 0, 0};
        for (int i = 0; i < 4; i++) cfg_rdata[i] = 8'($urandom);
        issue_sweep();
        n = 0;
        while (!(bus_req && bus_addr == SEL_ADDR1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait_entry1", bus_req && (bus_addr == SEL_ADDR1), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sweep_q.delete();
        req_q.delete();
        model_dato = '0;
        @(posedge clk);
        #1;
        check("mid_rst_bus_req", bus_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_selec", selec, 0);
        check("mid_rst_bus_addr", bus_addr, 0);
        check("mid_rst_dato0", dato0, 0);
        check("mid_rst_dato1", dato1, 0);
        check("mid_rst_dato2", dato2, 0);
        check("mid_rst_dato3", dato3, 0);
        @(negedge clk);
        reset = 1'b0;
        inject_req++;
        repeat (3) @(negedge clk);
        check("late_done_dato0", dato0, 0);
        check("late_done_dato1", dato1, 0);
        check("late_done_busy", busy, 0);
        check("late_done_bus_req", bus_req, 0);

        // recovery sweep after reset
        cfg_delay = '{0, 0, 0, 0};
        cfg_rdata = '{8'h5A, 8'hA5, 8'h0F, 8'hF0};
        issue_sweep();
        wait_idle(100);

        check("req_queue_drained", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
